// File: rtl/memory_store_unit.sv
// Store unit for the MEM stage: full-word stores are written directly, while
// halfword and byte stores read the target word, merge in the new lane and
// write the result back. busy stalls the pipeline while a store is in flight.
//
// state | meaning
// IDLE  | waiting for storeReq; the request is captured on the accepting edge
// READ  | read strobe issued for the captured word address
// MERGE | read data valid; merged word registered for the write
// WRITE | write strobe issued with done pulse
// ERR   | misaligned request rejected; misaligned pulse, no memory strobes
module memory_store_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  storeReq,
  input  logic [31:0]           address,
  input  logic [31:0]           dataIn,
  input  logic [1:0]            maskLength,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memReadEnable,
  input  logic [31:0]           memReadData,
  output logic                  memWriteEnable,
  output logic [31:0]           memWriteData,
  output logic                  busy,
  output logic                  done,
  output logic                  misaligned
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_e;

  state_e                state_q;
  logic [1:0]            lane_q;
  logic                  half_q;
  logic [15:0]           data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_re_q;
  logic                  mem_we_q;
  logic [31:0]           mem_wdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mis_q;

  logic                  is_word;
  logic                  is_half;
  logic                  bad_align;
  logic [31:0]           merged_d;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^address[31:ADDR_WIDTH+2];

  // Decode size and alignment of the incoming request; code 3 acts as a word.
  always_comb begin
    is_word   = (maskLength == 2'd0) || (maskLength == 2'd3);
    is_half   = (maskLength == 2'd1);
    bad_align = 1'b0;
    if (is_word)      bad_align = (address[1:0] != 2'b00);
    else if (is_half) bad_align = address[0];
  end

  // Replace only the selected lane of the read word with the captured data.
  always_comb begin
    merged_d = memReadData;
    if (half_q) begin
      if (lane_q[1]) merged_d[31:16] = data_q;
      else           merged_d[15:0]  = data_q;
    end else begin
      case (lane_q)
        2'd0:    merged_d[7:0]   = data_q[7:0];
        2'd1:    merged_d[15:8]  = data_q[7:0];
        2'd2:    merged_d[23:16] = data_q[7:0];
        default: merged_d[31:24] = data_q[7:0];
      endcase
    end
  end

  // Sequencer with registered outputs; strobes and pulses default low each cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lane_q      <= 2'b00;
      half_q      <= 1'b0;
      data_q      <= 16'h0000;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (storeReq) begin
            lane_q <= address[1:0];
            half_q <= is_half;
            data_q <= dataIn[15:0];
            busy_q <= 1'b1;
            if (bad_align) begin
              state_q <= ERR;
              mis_q   <= 1'b1;
            end else if (is_word) begin
              state_q     <= WRITE;
              mem_addr_q  <= address[ADDR_WIDTH+1:2];
              mem_we_q    <= 1'b1;
              mem_wdata_q <= dataIn;
              done_q      <= 1'b1;
            end else begin
              state_q    <= READ;
              mem_addr_q <= address[ADDR_WIDTH+1:2];
              mem_re_q   <= 1'b1;
            end
          end
        end
        READ: state_q <= MERGE;
        MERGE: begin
          state_q     <= WRITE;
          mem_we_q    <= 1'b1;
          mem_wdata_q <= merged_d;
          done_q      <= 1'b1;
        end
        WRITE, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign memAddr        = mem_addr_q;
  assign memReadEnable  = mem_re_q;
  assign memWriteEnable = mem_we_q;
  assign memWriteData   = mem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign misaligned     = mis_q;

endmodule

// File: doc/memory_store_unit.md
Name: memory_store_unit

Overview:
- Store-side counterpart of the load mask in the MIPS-style datapath.
- Takes a store request from the MEM stage (address, register data, size) and writes it into a word-wide synchronous data memory.
- Full-word stores go straight to memory. Halfword and byte stores use a read-modify-write sequence that merges the new lane into the existing word.
- Sits between the MEM-stage control and the data memory port. It raises busy so the pipeline can stall.

Parameters:
- ADDR_WIDTH, 10, word-address width of the data memory. The byte address uses bits [ADDR_WIDTH+1:2].

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- storeReq  input  1  store request. Sampled only in IDLE.
- address  input  32  byte address of the store.
- dataIn  input  32  store data. Significant bits are right-aligned: [7:0] for a byte, [15:0] for a halfword.
- maskLength  input  2  store size: 0 = word, 1 = halfword, 2 = byte, 3 = treated as word.
- memAddr  output  ADDR_WIDTH  word address to the data memory.
- memReadEnable  output  1  memory read strobe. Data is valid on memReadData one cycle later.
- memReadData  input  32  memory read data.
- memWriteEnable  output  1  memory write strobe, one cycle.
- memWriteData  output  32  full word written to memory.
- busy  output  1  unit is occupied; pipeline must stall.
- done  output  1  one-cycle pulse in the cycle the write is issued.
- misaligned  output  1  one-cycle pulse when a request is rejected for misalignment.

Behaviour:
- Byte lanes are little-endian. address[1:0] = k selects bits [8k+7:8k].
- Halfword lanes: address[1] = 0 selects [15:0]; address[1] = 1 selects [31:16].
- States: IDLE, READ, MERGE, WRITE, ERR.
- On reset assertion, all outputs go to 0 and state goes to IDLE, regardless of clock.
- Reset mid-operation aborts the store. No write occurs and captured data is discarded.
- IDLE, storeReq = 1: capture address, dataIn and maskLength on the rising edge.
  - Word (maskLength 0 or 3): go to WRITE. address[1:0] ≠ 0 → ERR.
  - Halfword: address[0] = 1 → ERR; otherwise READ.
  - Byte: always READ. No alignment constraint.
- IDLE, storeReq = 0: stay in IDLE.
- READ (1 cycle): memReadEnable = 1, memAddr = captured word address, then go to MERGE.
- MERGE (1 cycle): memReadData is valid. Register the merged word, which is memReadData with only the selected lane replaced by the captured data. Go to WRITE.
- WRITE (1 cycle): memWriteEnable = 1, memAddr = captured word address, done = 1.
  - memWriteData is the captured dataIn for a word store, or the merged word for a partial store.
  - Go to IDLE.
- ERR (1 cycle): misaligned = 1, no memory strobes, go to IDLE.
- busy = 1 in READ, MERGE, WRITE and ERR; 0 in IDLE.
  - busy is registered: it rises the cycle after acceptance and falls on return to IDLE.
- Latency from acceptance edge N:
  - Word: write at cycle N+1.
  - Partial: read at N+1, merge at N+2, write at N+3.
  - Misaligned: pulse at N+1.
- storeReq while busy is ignored. No queueing; the requester must hold or re-issue after busy drops.
- A new request may be accepted in the first IDLE cycle after WRITE or ERR, so back-to-back word stores take 2 cycles each.
- Outside WRITE, memWriteEnable = 0 and memWriteData is held at 0.
- Outside READ and WRITE, memAddr holds its last value.
- Memory strobes are never asserted simultaneously.
- Unused dataIn upper bits are ignored for partial stores. Lane replacement never touches the other lanes.

Test Plan:
- Word store: reset released; storeReq with address 0x10, dataIn 0xDEADBEEF, maskLength 0 → next cycle memWriteEnable = 1, memAddr = 4, memWriteData = 0xDEADBEEF, done = 1; busy high exactly one cycle.
- Byte store: memory word 4 = 0x11223344; store byte 0xAB at address 0x12 → READ at N+1, WRITE at N+3 with memWriteData = 0x11AB3344, done pulse.
- Halfword store: memory word 4 = 0x11223344; store halfword 0xCAFE at address 0x12 → memWriteData = 0xCAFE3344. Repeat at address 0x10 → 0x1122CAFE.
- Misalignment: halfword at 0x11 → misaligned pulse at N+1, no strobes. Word at 0x12 → same response.
- Busy handling: hold storeReq high with a new word request during a byte store's READ/MERGE → request ignored until IDLE, then accepted; exactly two writes with the correct data.
- Reset mid-operation: assert reset in MERGE → outputs 0 immediately, no write; after release the unit is IDLE and accepts a word store normally.
